// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory port
// and captures the returned word plus PC+4 into the IF/ID pipeline register.
// Per-edge priority is reset > redirect > stall > advance.
module if_fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_read,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [ADDR_W-1:0] pc_out
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_inc;

  // Sequential PC wraps modulo 2^ADDR_W; no overflow detection is wanted.
  assign pc_inc = pc_q + ADDR_W'(4);

  // Memory port and debug view follow the live PC; reads stop while held.
  assign imem_addr   = pc_q;
  assign imem_read   = rst_n & ~stall;
  assign pc_out      = pc_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = pc4_q;
  assign if_valid    = valid_q;
  assign fetch_count = cnt_q;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      // Target low bits are dropped so the PC stays word-aligned; the
      // IF/ID slot becomes a bubble (all-zero word encodes NOP).
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_inc;
      instr_d = imem_rdata;
      pc4_d   = pc_inc;
      valid_d = 1'b1;
      cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, random stimulus against
// a behavioural model, and a long run for counter saturation.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [7:0]  if_pc_plus4;
  logic        if_valid;
  logic [15:0] fetch_count;
  logic [7:0]  pc_out;

  logic [31:0] mem [64];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_read      (imem_read),
    .imem_rdata     (imem_rdata),
    .if_instr       (if_instr),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .fetch_count    (fetch_count),
    .pc_out         (pc_out)
  );

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [7:0]  rpc;
    logic        exp_read;
    logic [7:0]  exp_pc;
    logic [31:0] exp_instr;
    logic [7:0]  exp_pc4;
    logic        exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] rp,
                              input logic rd, input logic [7:0] pc, input logic [31:0] ins,
                              input logic [7:0] p4, input logic vl, input logic [15:0] c);
    vec_t t;
    t.rst_n = r; t.stall = s; t.rv = v; t.rpc = rp; t.exp_read = rd;
    t.exp_pc = pc; t.exp_instr = ins; t.exp_pc4 = p4; t.exp_valid = vl; t.exp_cnt = c;
    return t;
  endfunction

  // Behavioural reference state (plain integers, spec rules).
  int m_pc, m_pc4, m_cnt;
  logic [31:0] m_instr;
  logic m_valid;

  task automatic model_edge(input logic r, input logic s, input logic v, input int rp);
    if (!r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    end else if (v) begin
      m_pc = rp - (rp % 4); m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = mem[m_pc / 4];
      m_pc    = (m_pc + 4) % 256;
      m_pc4   = m_pc;
      m_valid = 1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0]  = 32'h200f0008;
    mem[1]  = 32'hac0f0000;
    mem[2]  = 32'h200f0017;
    mem[3]  = 32'hac0f0001;
    mem[10] = 32'h03bee022;

    //            rst s  rv rpc    rd pc     instr          pc4    v  cnt
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 32'h200f0008,  8'h04, 1, 16'd1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h08, 32'hac0f0000,  8'h08, 1, 16'd2));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h08, 32'hac0f0000,  8'h08, 1, 16'd2));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h08, 32'hac0f0000,  8'h08, 1, 16'd2));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h08, 32'hac0f0000,  8'h08, 1, 16'd2));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h0C, 32'h200f0017,  8'h0C, 1, 16'd3));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h10, 32'hac0f0001,  8'h10, 1, 16'd4));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h14, 32'hA0000004,  8'h14, 1, 16'd5));
    vecs.push_back(mk(1, 1, 1, 8'h29, 0, 8'h28, 32'h0,         8'h00, 0, 16'd5));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h2C, 32'h03bee022,  8'h2C, 1, 16'd6));
    vecs.push_back(mk(1, 0, 1, 8'hFC, 1, 8'hFC, 32'h0,         8'h00, 0, 16'd6));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 32'hA000003F,  8'h00, 1, 16'd7));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 32'h200f0008,  8'h04, 1, 16'd8));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h08, 32'hac0f0000,  8'h08, 1, 16'd9));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h0C, 32'h200f0017,  8'h0C, 1, 16'd10));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h10, 32'hac0f0001,  8'h10, 1, 16'd11));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h14, 32'hA0000004,  8'h14, 1, 16'd12));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(0, 0, 1, 8'h40, 0, 8'h00, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 1, 8'h30, 1, 8'h30, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 1, 8'h47, 1, 8'h44, 32'h0,         8'h00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h48, 32'hA0000011,  8'h48, 1, 16'd1));

    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);

    // Directed table: check combinational read enable before the edge,
    // registered state after it.
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; stall = vecs[i].stall;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d imem_read", i), {31'b0, imem_read}, {31'b0, vecs[i].exp_read});
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc_out", i), {24'b0, pc_out}, {24'b0, vecs[i].exp_pc});
      chk($sformatf("vec%0d imem_addr", i), {24'b0, imem_addr}, {24'b0, vecs[i].exp_pc});
      chk($sformatf("vec%0d if_instr", i), if_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d if_pc_plus4", i), {24'b0, if_pc_plus4}, {24'b0, vecs[i].exp_pc4});
      chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d fetch_count", i), {16'b0, fetch_count}, {16'b0, vecs[i].exp_cnt});
      $display("vec %0d: rst_n=%b stall=%b rv=%b rpc=%h -> pc=%h instr=%h pc4=%h v=%b cnt=%0d",
               i, vecs[i].rst_n, vecs[i].stall, vecs[i].rv, vecs[i].rpc,
               pc_out, if_instr, if_pc_plus4, if_valid, fetch_count);
      @(negedge clk);
    end

    // Random stimulus against the reference model; first step resets both.
    for (int i = 0; i < 1500; i++) begin
      logic r, s, v;
      int rp;
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 99) >= 3);
      s  = ($urandom_range(0, 99) < 30);
      v  = ($urandom_range(0, 99) < 12);
      rp = $urandom_range(0, 255);
      rst_n = r; stall = s; redirect_valid = v; redirect_pc = rp[7:0];
      #1;
      chk($sformatf("rnd%0d imem_read", i), {31'b0, imem_read}, {31'b0, r & ~s});
      if (i > 0) chk($sformatf("rnd%0d imem_addr", i), {24'b0, imem_addr}, m_pc);
      model_edge(r, s, v, rp);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d pc_out", i), {24'b0, pc_out}, m_pc);
      chk($sformatf("rnd%0d if_instr", i), if_instr, m_instr);
      chk($sformatf("rnd%0d if_pc_plus4", i), {24'b0, if_pc_plus4}, m_pc4);
      chk($sformatf("rnd%0d if_valid", i), {31'b0, if_valid}, {31'b0, m_valid});
      chk($sformatf("rnd%0d fetch_count", i), {16'b0, fetch_count}, m_cnt);
      $display("rnd %0d: rst_n=%b stall=%b rv=%b rpc=%h -> pc=%h v=%b cnt=%0d",
               i, r, s, v, rp[7:0], pc_out, if_valid, fetch_count);
      @(negedge clk);
    end

    // Counter saturation: reset, then a long unbroken run of advances.
    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 65540; i++) begin
      @(negedge clk);
      if (i == 65534) chk("sat below max", {16'b0, fetch_count}, 32'd65534);
      if (i == 65535) chk("sat reach max", {16'b0, fetch_count}, 32'h0000FFFF);
    end
    chk("sat held", {16'b0, fetch_count}, 32'h0000FFFF);
    $display("sat: after 65540 advances fetch_count=%h", fetch_count);
    stall = 1;
    @(negedge clk);
    chk("sat under stall", {16'b0, fetch_count}, 32'h0000FFFF);
    stall = 0;
    @(negedge clk);
    chk("sat one more", {16'b0, fetch_count}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU; sits directly upstream of the instruction memory bank (8-bit byte address, 32-bit word, word index = addr>>2) and feeds the IF/ID boundary.
- Holds the program counter and drives the memory address and read enable.
- Registers the returned instruction word together with PC+4 into the IF/ID pipeline register.
- Handles hazard stall, branch/jump redirect with flush, and keeps a fetch counter for performance checks.

Parameters:
- ADDR_W, 8, PC / instruction-memory byte-address width
- DATA_W, 32, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset (must be word-aligned)
- CNT_W, 16, width of the fetched-instruction counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect_valid  in  1  branch/jump taken (from ID/EX); load new PC, flush IF/ID
- redirect_pc  in  ADDR_W  target byte address
- imem_addr  out  ADDR_W  byte address to instruction memory (= pc, combinational)
- imem_read  out  1  memory read enable
- imem_rdata  in  DATA_W  instruction word from memory, valid within the same cycle
- if_instr  out  DATA_W  IF/ID register: instruction
- if_pc_plus4  out  ADDR_W  IF/ID register: address of the next sequential instruction
- if_valid  out  1  IF/ID register holds a real instruction (0 = bubble)
- fetch_count  out  CNT_W  instructions accepted into IF/ID since reset
- pc_out  out  ADDR_W  current PC, for debug

Behaviour:
- Reset (rst_n=0 at a clk edge) takes priority over everything:
  - pc <= RESET_PC; if_instr <= 0 (encodes NOP); if_pc_plus4 <= 0; if_valid <= 0; fetch_count <= 0.
  - imem_read = 0 while rst_n=0.
  - A reset mid-stream discards any in-flight instruction; there is no partial state.
- Combinational outputs:
  - imem_addr = pc.
  - imem_read = rst_n & ~stall.
  - pc_out = pc.
- Per-edge priority when rst_n=1: redirect > stall > advance.
- Redirect (redirect_valid=1), applied even when stall=1:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; the low two bits are silently dropped.
  - IF/ID flushed: if_valid <= 0, if_instr <= 0, if_pc_plus4 <= 0.
  - fetch_count unchanged.
- Stall (stall=1, redirect_valid=0): pc, if_instr, if_pc_plus4, if_valid and fetch_count all hold.
- Advance (stall=0, redirect_valid=0):
  - if_instr <= imem_rdata; if_pc_plus4 <= pc+4; if_valid <= 1; pc <= pc+4.
  - fetch_count <= fetch_count+1, saturating at all-ones.
- Arithmetic:
  - PC adds are ADDR_W wide and wrap modulo 2^ADDR_W (8'hFC + 4 = 8'h00); no overflow flag.
  - pc is always word-aligned.
- Latency:
  - An instruction at address A appears on if_instr one edge after pc==A with stall=0.
  - First valid if_instr appears on the first edge after rst_n returns high.
  - The first instruction after a redirect appears two edges after redirect_valid is sampled: one edge loads pc, the next captures the instruction. This is a single bubble.
- Back-to-back redirects: each one reloads pc and flushes; the last one wins.
- No X propagation: all registers have defined reset values; imem_rdata is only sampled on an advance.

Test Plan:
- Reset then release with memory[0..3] = 200f0008, ac0f0000, 200f0017, ac0f0001 -> imem_addr walks 00,04,08,0C; after edges 1–4 if_instr = those words, if_pc_plus4 = 04,08,0C,10, if_valid=1, fetch_count=4.
- stall=1 for 3 cycles at pc=08 -> pc, if_instr=ac0f0000, if_pc_plus4=08 and fetch_count all frozen; imem_read=0; fetch resumes at 08 when stall drops.
- redirect_valid=1, redirect_pc=8'h29 with stall=1 in the same cycle -> next edge pc=28, if_valid=0, if_instr=0; following edge if_instr=mem[10]=03bee022, if_pc_plus4=2C.
- Preload pc near top via redirect_pc=8'hFC -> fetches FC, then imem_addr=00; if_pc_plus4=00 for the instruction fetched at FC.
- rst_n=0 for one edge mid-stream (pc=14, if_valid=1) -> pc=00, if_valid=0, if_instr=0, fetch_count=0; rst_n low with redirect_valid=1 -> reset wins.
- Force 65540 advances -> fetch_count saturates at 16'hFFFF and stays there.
